lsu: RTL and testbench

Load/store unit sitting between the core's execute stage and the data port (port 2) of the byte-addressed RAM. Accepts one RV32I load/store per handshake, drives word-aligned RAM accesses, performs byte/halfword extraction with sign/zero extension on loads, and read-modify-write for SB/SH because the RAM port only writes full words. Returns one response per request, with an error flag for misaligned, invalid or out-of-range accesses.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/lsu_lane.sv | 64 ++++++
 rtl/lsu.sv | 171 +++++++++++++++++
 tb/tb_lsu.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions for the LSU slice.
// Contents: funct3 width encodings and the LSU controller state type.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    MERGE_WR = 2'd2,
    RESP     = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane datapath for the LSU (purely combinational).
// Ports:
//   word      in  32  word read from RAM
//   wdata     in  32  store data (low byte/halfword used for SB/SH)
//   addr_lo   in  2   byte offset within the word
//   funct3    in  3   access width / signedness
//   load_data out 32  extracted and extended load result
//   merge_wd  out 32  old word with the store lane replaced
module lsu_lane
  import riscv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] merge_wd
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      F3_W:    load_data = word;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    merge_wd = word;
    case (funct3)
      F3_B: begin
        case (addr_lo)
          2'd0:    merge_wd[7:0]   = wdata[7:0];
          2'd1:    merge_wd[15:8]  = wdata[7:0];
          2'd2:    merge_wd[23:16] = wdata[7:0];
          default: merge_wd[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (addr_lo[1]) merge_wd[31:16] = wdata[15:0];
        else            merge_wd[15:0]  = wdata[15:0];
      end
      F3_W:    merge_wd = wdata;
      default: merge_wd = word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between the execute stage and RAM data port 2.
// One RV32I load/store per req handshake, one response per request.
// SB/SH use read-modify-write since the RAM port writes whole words.
// Ports:
//   clk, rst (sync, active high)
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : request
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                    : response
//   mem_addr/mem_rd/mem_we/mem_wd                            : RAM port
// Parameters: START_ADDR (first RAM byte), MEM_SIZE (bytes, multiple of 4).
// Macro LSU_RANGE_CHECK_EN: reject accesses outside the RAM window.
module lsu
  import riscv_pkg::*;
#(
  parameter logic [31:0] START_ADDR = 32'h0,
  parameter int unsigned MEM_SIZE   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rd,
  output logic        mem_we,
  output logic [31:0] mem_wd
);

`ifdef LSU_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  // 33-bit window bounds so an access ending past 0xFFFFFFFF cannot wrap.
  localparam logic [32:0] RANGE_LO = {1'b0, START_ADDR};
  localparam logic [32:0] RANGE_HI = {1'b0, START_ADDR} + 33'(MEM_SIZE) - 33'd1;

  lsu_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  // Doubles as the merge register for SB/SH.
  logic [31:0] mem_wd_q, mem_wd_d;
  logic        mem_we_c;

  logic [32:0] word_lo, word_hi;
  logic        range_err, req_err;
  logic [31:0] lane_load, lane_merge;

  lsu_lane u_lane (
    .word      (mem_rd),
    .wdata     (wdata_q),
    .addr_lo   (addr_lo_q),
    .funct3    (funct3_q),
    .load_data (lane_load),
    .merge_wd  (lane_merge)
  );

  always_comb begin
    word_lo   = {1'b0, req_addr[31:2], 2'b00};
    word_hi   = word_lo + 33'd3;
    range_err = (word_lo < RANGE_LO) || (word_hi > RANGE_HI);

    if (req_we) req_err = !(req_funct3 inside {F3_B, F3_H, F3_W});
    else        req_err = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    if ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0])
      req_err = 1'b1;
    if (req_funct3 == F3_W && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
    if (RANGE_EN && range_err)
      req_err = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_lo_d  = addr_lo_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    mem_we_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d      = req_we;
          funct3_d  = req_funct3;
          addr_lo_d = req_addr[1:0];
          wdata_d   = req_wdata;
          rdata_d   = '0;
          err_d     = req_err;
          if (req_err) begin
            state_d = RESP;
          end else begin
            state_d    = ACCESS;
            mem_addr_d = {req_addr[31:2], 2'b00};
            // SW data must already be on mem_wd during ACCESS.
            if (req_we && req_funct3 == F3_W) mem_wd_d = req_wdata;
          end
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rdata_d = lane_load;
          state_d = RESP;
        end else if (funct3_q == F3_W) begin
          mem_we_c = 1'b1;
          state_d  = RESP;
        end else begin
          mem_wd_d = lane_merge;
          state_d  = MERGE_WR;
        end
      end
      MERGE_WR: begin
        mem_we_c = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      addr_lo_q  <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      addr_lo_q  <= addr_lo_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
    end
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wd    = mem_wd_q;
  assign mem_we    = mem_we_c && !rst;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu with START_ADDR=0, MEM_SIZE=64.
// Expected responses are queued when a request is driven and compared when
// the response appears. Define LSU_RANGE_CHECK_EN for both RTL and bench.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr, mem_rd, mem_wd;
  logic        mem_we;

  logic [31:0] ram [16] = '{default: '0};

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwe;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  lsu #(.START_ADDR(32'h0), .MEM_SIZE(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_we(mem_we), .mem_wd(mem_wd)
  );

  assign mem_rd = ram[mem_addr[5:2]];
  always @(posedge clk) if (mem_we) ram[mem_addr[5:2]] <= mem_wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic run_req(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] x_rdata, input logic x_err,
                         input int x_lat, input int x_nwe, input int hold);
    exp_t e;
    int n, lat, nwe;
    bit got;
    e.name = name; e.rdata = x_rdata; e.err = x_err; e.lat = x_lat; e.nwe = x_nwe;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    rsp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      check({name, "_accept_timeout"}, 0, 1);
      req_valid = 1'b0;
      void'(sb.pop_front());
      return;
    end
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0; nwe = 0; got = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (mem_we) nwe++;
      if (rsp_valid) begin got = 1; lat = k; end
    end
    e = sb.pop_front();
    if (!got) begin
      check({e.name, "_rsp_timeout"}, 0, 1);
      rsp_ready = 1'b1;
      return;
    end
    check({e.name, "_rdata"}, rsp_rdata, e.rdata);
    check({e.name, "_err"}, 32'(rsp_err), 32'(e.err));
    check({e.name, "_lat"}, lat, e.lat);
    check({e.name, "_we_cycles"}, nwe, e.nwe);
    for (int h = 0; h < hold; h++) begin
      check({e.name, "_hold_valid"}, 32'(rsp_valid), 1);
      check({e.name, "_hold_rdata"}, rsp_rdata, e.rdata);
      check({e.name, "_hold_err"}, 32'(rsp_err), 32'(e.err));
      check({e.name, "_hold_ready"}, 32'(req_ready), 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check({e.name, "_valid_drop"}, 32'(rsp_valid), 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", 32'(rsp_err), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wd", mem_wd, 0);
    check("rst_ready", 32'(req_ready), 0);
    rst = 1'b0;

    run_req("sw",   1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 1, 0);
    run_req("lw1",  0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 0, 0);
    run_req("sb",   1, 3'b000, 32'h11, 32'h123456A5, 32'h0,        0, 3, 1, 0);
    run_req("lw2",  0, 3'b010, 32'h10, 32'h0,        32'hDEADA5EF, 0, 2, 0, 0);
    run_req("lb",   0, 3'b000, 32'h11, 32'h0,        32'hFFFFFFA5, 0, 2, 0, 0);
    run_req("lbu",  0, 3'b100, 32'h11, 32'h0,        32'h000000A5, 0, 2, 0, 0);
    run_req("lh",   0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 0, 2, 0, 0);
    run_req("lhu",  0, 3'b101, 32'h12, 32'h0,        32'h0000DEAD, 0, 2, 0, 0);

    run_req("e_lw_mis", 0, 3'b010, 32'h12, 32'h0,    32'h0, 1, 1, 0, 0);
    run_req("e_sh_mis", 1, 3'b001, 32'h13, 32'hFFFF, 32'h0, 1, 1, 0, 0);
    run_req("e_ld_f3",  0, 3'b011, 32'h0,  32'h0,    32'h0, 1, 1, 0, 0);
    run_req("e_st_f3",  1, 3'b100, 32'h0,  32'h1234, 32'h0, 1, 1, 0, 0);

`ifdef LSU_RANGE_CHECK_EN
    run_req("r_lw40",   0, 3'b010, 32'h40,       32'h0, 32'h0, 1, 1, 0, 0);
    run_req("r_lwwrap", 0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 1, 1, 0, 0);
`else
    run_req("r_lw40",   0, 3'b010, 32'h40,       32'h0, 32'h0, 0, 2, 0, 0);
    check("r_lw40_addr", mem_addr, 32'h40);
    run_req("r_lwwrap", 0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 0, 2, 0, 0);
`endif

    run_req("bp_lw", 0, 3'b010, 32'h10, 32'h0, 32'hDEADA5EF, 0, 2, 0, 3);

    // Reset during MERGE_WR of SH 0xBEEF @0x10.
    @(negedge clk);
    check("rr_ready_pre", 32'(req_ready), 1);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h10; req_wdata = 32'h0000BEEF;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("rr_we", 32'(mem_we), 0);
    check("rr_valid", 32'(rsp_valid), 0);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check("rr_ready_post", 32'(req_ready), 1);
    check("rr_valid_post", 32'(rsp_valid), 0);
    run_req("rr_lw", 0, 3'b010, 32'h10, 32'h0, 32'hDEADA5EF, 0, 2, 0, 0);

    run_req("sh",    1, 3'b001, 32'h12, 32'h0000BEEF, 32'h0,        0, 3, 1, 0);
    run_req("lw3",   0, 3'b010, 32'h10, 32'h0,        32'hBEEFA5EF, 0, 2, 0, 0);

    check("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
